nibble_alu_seq: RTL

Nibble-serial arithmetic sequencer for the T80-derived CPU core. It accepts an 8-bit or 16-bit ADD/ADC/SUB/SBC/CP request and drives a shared external 4-bit add/sub slice once per clock, lowest nibble first. It chains the slice carry and assembles the result. It computes Z80-style flags (C, H, V, Z, S, N) and hands the result back with a busy/done handshake. It sits between the instruction decoder and the single 4-bit slice, so one adder serves both 8-bit ALU ops and 16-bit pointer arithmetic.

---
 rtl/nibble_alu_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nibble_alu_seq.sv
// nibble_alu_seq: nibble-serial ADD/ADC/SUB/SBC/CP sequencer that drives one
// shared external 4-bit add/sub slice, lowest nibble first, and assembles the
// result and Z80-style flags.
// Build option: define NIBBLE_SEQ_WIDE16_EN to honor 'wide' (16-bit ops over
// 4 nibbles). Without it every op is 8-bit and the nibble index is 1 bit.
module nibble_alu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        wide,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cf_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        flag_c,
   output logic        flag_h,
   output logic        flag_v,
   output logic        flag_z,
   output logic        flag_s,
   output logic        flag_n,
   output logic        slice_en,
   output logic [3:0]  slice_a,
   output logic [3:0]  slice_b,
   output logic        slice_sub,
   output logic        slice_cin,
   input  logic [3:0]  slice_res,
   input  logic        slice_cout
);

`ifdef NIBBLE_SEQ_WIDE16_EN
   localparam int IW = 2;
`else
   localparam int IW = 1;
`endif
   localparam int DW = 4 << IW;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_last, idx_half;
   logic [IW+1:0] nib_base;
   logic [DW-1:0] a_q, b_q, shadow_q, sum_w;
   logic          sub_q, cp_q, cin0_q, cy_q, h_q;
   logic          op_sub, op_cin;
   logic          accept, last;
   logic          res_msb, a_msb, b_msb, zero_w;
   logic [15:0]   result_w;

   assign nib_base = {idx_q, 2'b00};
   assign last     = (idx_q == idx_last);
   assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef NIBBLE_SEQ_WIDE16_EN
   logic wide_q;

   assign idx_last = wide_q ? 2'd3 : 2'd1;
   assign idx_half = wide_q ? 2'd2 : 2'd0;
   assign res_msb  = wide_q ? sum_w[15] : sum_w[7];
   assign a_msb    = wide_q ? a_q[15] : a_q[7];
   assign b_msb    = wide_q ? b_q[15] : b_q[7];
   assign zero_w   = wide_q ? (sum_w == '0) : (sum_w[7:0] == 8'h00);
   assign result_w = cp_q ? (wide_q ? a_q : {8'h00, a_q[7:0]})
                          : (wide_q ? sum_w : {8'h00, sum_w[7:0]});

   // Operation width is latched together with the rest of the request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       wide_q <= 1'b0;
      else if (accept) wide_q <= wide;
   end
`else
   logic unused_hi;

   assign idx_last  = 1'b1;
   assign idx_half  = 1'b0;
   assign res_msb   = sum_w[7];
   assign a_msb     = a_q[7];
   assign b_msb     = b_q[7];
   assign zero_w    = (sum_w == '0);
   assign result_w  = {8'h00, (cp_q ? a_q : sum_w)};
   assign unused_hi = ^{wide, a[15:8], b[15:8]};
`endif

   // Decode operation class and the carry fed into nibble 0.
   always_comb begin
      op_sub = 1'b0;
      op_cin = 1'b0;
      case (op)
         3'b001:         op_cin = cf_in;
         3'b010, 3'b100: begin op_sub = 1'b1; op_cin = 1'b1;   end
         3'b011:         begin op_sub = 1'b1; op_cin = ~cf_in; end
         default:        ;
      endcase
   end

   // Shadow result with the nibble currently on the slice merged in.
   always_comb begin
      sum_w = shadow_q;
      sum_w[nib_base +: 4] = slice_res;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state, handshake and slice drive; slice is quiet outside RUN.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      slice_en  = 1'b0;
      slice_a   = 4'h0;
      slice_b   = 4'h0;
      slice_sub = 1'b0;
      slice_cin = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            busy      = 1'b1;
            slice_en  = 1'b1;
            slice_a   = a_q[nib_base +: 4];
            slice_b   = b_q[nib_base +: 4];
            slice_sub = sub_q;
            slice_cin = (idx_q == '0) ? cin0_q : cy_q;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = start ? S_RUN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Latch request, step the nibble index and chain the slice carry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         cp_q     <= 1'b0;
         cin0_q   <= 1'b0;
         idx_q    <= '0;
         shadow_q <= '0;
         cy_q     <= 1'b0;
         h_q      <= 1'b0;
      end else if (accept) begin
         a_q      <= a[DW-1:0];
         b_q      <= b[DW-1:0];
         sub_q    <= op_sub;
         cp_q     <= (op == 3'b100);
         cin0_q   <= op_cin;
         idx_q    <= '0;
         shadow_q <= '0;
         cy_q     <= 1'b0;
         h_q      <= 1'b0;
      end else if (state_q == S_RUN) begin
         shadow_q <= sum_w;
         cy_q     <= slice_cout;
         if (idx_q == idx_half) h_q <= slice_cout;
         idx_q    <= idx_q + IW'(1);
      end
   end

   // Publish result and flags only on the last nibble (entry into DONE).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result <= 16'h0000;
         flag_c <= 1'b0;
         flag_h <= 1'b0;
         flag_v <= 1'b0;
         flag_z <= 1'b0;
         flag_s <= 1'b0;
         flag_n <= 1'b0;
      end else if (state_q == S_RUN && last) begin
         result <= result_w;
         flag_c <= slice_cout ^ sub_q;
         flag_h <= h_q ^ sub_q;
         flag_v <= (a_msb == (b_msb ^ sub_q)) && (res_msb != a_msb);
         flag_z <= zero_w;
         flag_s <= res_msb;
         flag_n <= sub_q;
      end
   end

endmodule
